modem_tx_serializer: RTL and testbench

Transmit-side serializer for the LED comm demo. It accepts 7-bit words over a valid/ready handshake and buffers them in a small FIFO. Each word is emitted MSB-first as a serial stream on `data_out`, with a one-cycle active-low `lock` strobe per bit. The block sits directly upstream of the LED receiver, which shifts `data_out` into its 7-bit display register on every `sys_clk` in which `lock` is low.

---
 rtl/modem_tx_serializer_pkg.sv | 13 +
 rtl/modem_tx_serializer_if.sv | 28 ++
 rtl/modem_tx_fifo.sv | 67 ++++++
 rtl/modem_tx_serializer.sv | 126 ++++++++++++
 tb/tb_modem_tx_serializer.sv | 271 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/modem_tx_serializer_pkg.sv
// Shared constants and FSM encoding for the modem transmit serializer.
// The receiver imports the same word width so both ends stay in step.
package modem_tx_serializer_pkg;

    localparam int MODEM_WORD_W = 7;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } tx_state_e;

endpackage

// File: rtl/modem_tx_serializer_if.sv
// Word-input handshake plus serial-side outputs of the transmit serializer.
// The source drives through master; the serializer sits on slave.
interface modem_tx_serializer_if #(
    parameter int WORD_W     = modem_tx_serializer_pkg::MODEM_WORD_W,
    parameter int FIFO_DEPTH = 4
) ();

    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic [WORD_W-1:0]  wr_data;
    logic               wr_valid;
    logic               wr_ready;
    logic               data_out;
    logic               lock;
    logic               busy;
    logic [LEVEL_W-1:0] fifo_level;

    modport master (
        output wr_data, wr_valid,
        input  wr_ready, data_out, lock, busy, fifo_level
    );

    modport slave (
        input  wr_data, wr_valid,
        output wr_ready, data_out, lock, busy, fifo_level
    );

endinterface

// File: rtl/modem_tx_fifo.sv
// Small synchronous word FIFO with registered full/empty flags and fill level.
// Push while full and pop while empty are ignored, so callers need no extra guarding.
module modem_tx_fifo #(
    parameter int WIDTH = 7,
    parameter int DEPTH = 4
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       push_data_i,
    input  logic                   pop_i,
    output logic [WIDTH-1:0]       pop_data_o,
    output logic                   full_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] level_o
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;

    logic [WIDTH-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] count_q, count_d;
    logic               full_q, full_d;
    logic               empty_q, empty_d;
    logic               do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        count_d  = count_q + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
        full_d   = (count_d == LEVEL_W'(DEPTH));
        empty_d  = (count_d == '0);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // NOTE: storage has no reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge sys_clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign pop_data_o = mem_q[rd_ptr_q];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign level_o    = count_q;

endmodule

// File: rtl/modem_tx_serializer.sv
// Buffers words and emits each MSB-first on data_out, with a one-cycle low lock strobe
// at the end of every bit slot, followed by an idle gap of GAP_SLOTS slots.
module modem_tx_serializer
    import modem_tx_serializer_pkg::*;
#(
    parameter int WORD_W     = MODEM_WORD_W,
    parameter int BIT_DIV    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_SLOTS  = 2
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    modem_tx_serializer_if.slave  bus
);

    localparam int DIV_W   = $clog2(BIT_DIV);
    localparam int BIT_W   = $clog2(WORD_W);
    localparam int GAP_LEN = GAP_SLOTS * BIT_DIV;
    localparam int GAP_W   = $clog2(GAP_LEN + 2);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WORD_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);

    tx_state_e          state_q, state_d;
    logic [WORD_W-1:0]  shreg_q, shreg_d;
    logic [BIT_W-1:0]   bit_idx_q, bit_idx_d;
    logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
    logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic               data_out_q, data_out_d;
    logic               lock_q, lock_d;
    logic               busy_q, busy_d;

    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [WORD_W-1:0]  fifo_data;

    modem_tx_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk     (sys_clk),
        .reset       (reset),
        .push_i      (bus.wr_valid),
        .push_data_i (bus.wr_data),
        .pop_i       (fifo_pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (bus.fifo_level)
    );

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        bit_idx_d = bit_idx_q;
        div_cnt_d = div_cnt_q;
        gap_cnt_d = gap_cnt_q;
        fifo_pop  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shreg_d   = fifo_data;
                    bit_idx_d = '0;
                    div_cnt_d = '0;
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    shreg_d   = {shreg_q[WORD_W-2:0], 1'b0};
                    bit_idx_d = bit_idx_q + BIT_W'(1);
                    if (bit_idx_q == BIT_LAST) begin
                        gap_cnt_d = '0;
                        state_d   = (GAP_SLOTS == 0) ? ST_IDLE : ST_GAP;
                    end
                end else begin
                    div_cnt_d = div_cnt_q + DIV_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ST_IDLE;
                else                       gap_cnt_d = gap_cnt_q + GAP_W'(1);
            end
            default: state_d = ST_IDLE;
        endcase

        // Outputs are decoded from next-state values so the flops line up with the state they describe.
        data_out_d = (state_d == ST_SHIFT) && shreg_d[WORD_W-1];
        lock_d     = !((state_d == ST_SHIFT) && (div_cnt_d == DIV_LAST));
        busy_d     = (state_d != ST_IDLE);
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shreg_q    <= '0;
            bit_idx_q  <= '0;
            div_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            data_out_q <= 1'b0;
            lock_q     <= 1'b1;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_idx_q  <= bit_idx_d;
            div_cnt_q  <= div_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            data_out_q <= data_out_d;
            lock_q     <= lock_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.wr_ready = !fifo_full;
    assign bus.data_out = data_out_q;
    assign bus.lock     = lock_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_modem_tx_serializer.sv
// Directed bench: a receiver model shifts data_out on every low lock and the
// strobe timing, word contents, FIFO boundaries, reset and zero-gap spacing are checked.
module tb_modem_tx_serializer;

    localparam int WORD_W     = 7;
    localparam int BIT_DIV    = 4;
    localparam int FIFO_DEPTH = 4;

    typedef struct {
        int   at;
        logic bit_v;
    } strobe_t;

    logic sys_clk = 1'b0;
    logic reset   = 1'b1;
    int   cyc     = 0;

    int n_checks = 0;
    int n_fail   = 0;

    modem_tx_serializer_if #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) bus  ();
    modem_tx_serializer_if #(.WORD_W(WORD_W), .FIFO_DEPTH(FIFO_DEPTH)) bus0 ();

    modem_tx_serializer #(
        .WORD_W(WORD_W), .BIT_DIV(BIT_DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_SLOTS(2)
    ) dut (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus)
    );

    modem_tx_serializer #(
        .WORD_W(WORD_W), .BIT_DIV(BIT_DIV), .FIFO_DEPTH(FIFO_DEPTH), .GAP_SLOTS(0)
    ) dut_gap0 (
        .sys_clk (sys_clk),
        .reset   (reset),
        .bus     (bus0)
    );

    always #5 sys_clk = ~sys_clk;

    always @(posedge sys_clk) cyc <= cyc + 1;

    // Receiver models and event logs, sampled on the falling edge.
    strobe_t            strobes[$];
    strobe_t            strobes0[$];
    logic [WORD_W-1:0]  words[$];
    logic [WORD_W-1:0]  words0[$];
    int                 busy_rise0[$];
    logic [WORD_W-1:0]  rx  = '0;
    logic [WORD_W-1:0]  rx0 = '0;
    int                 nbits  = 0;
    int                 nbits0 = 0;
    int                 busy_first = -1;
    int                 busy_last  = -1;
    int                 level_peak = 0;
    logic               busy0_prev = 1'b0;

    always @(negedge sys_clk) begin
        if (reset) begin
            nbits = 0;
            rx    = '0;
        end else if (!bus.lock) begin
            strobes.push_back('{cyc, bus.data_out});
            rx = {rx[WORD_W-2:0], bus.data_out};
            nbits++;
            if (nbits == WORD_W) begin
                words.push_back(rx);
                nbits = 0;
            end
        end
        if (bus.busy) begin
            if (busy_first < 0) busy_first = cyc;
            busy_last = cyc;
        end
        if (int'(bus.fifo_level) > level_peak) level_peak = int'(bus.fifo_level);
    end

    always @(negedge sys_clk) begin
        if (reset) begin
            nbits0 = 0;
            rx0    = '0;
        end else if (!bus0.lock) begin
            strobes0.push_back('{cyc, bus0.data_out});
            rx0 = {rx0[WORD_W-2:0], bus0.data_out};
            nbits0++;
            if (nbits0 == WORD_W) begin
                words0.push_back(rx0);
                nbits0 = 0;
            end
        end
        if (bus0.busy && !busy0_prev) busy_rise0.push_back(cyc);
        busy0_prev = bus0.busy;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_logs();
        strobes.delete();
        words.delete();
        strobes0.delete();
        words0.delete();
        busy_rise0.delete();
        busy_first = -1;
        busy_last  = -1;
        level_peak = 0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int                t0;
        logic [WORD_W-1:0] w;

        bus.wr_data   = '0;
        bus.wr_valid  = 1'b0;
        bus0.wr_data  = '0;
        bus0.wr_valid = 1'b0;

        // Reset state, observed while reset is held.
        wait_cycles(2);
        check("rst wr_ready", bus.wr_ready, 1);
        check("rst lock", bus.lock, 1);
        check("rst data_out", bus.data_out, 0);
        check("rst busy", bus.busy, 0);
        check("rst fifo_level", bus.fifo_level, 0);
        reset = 1'b0;
        wait_cycles(2);

        // Single word 7'h5A.
        clear_logs();
        t0 = cyc;
        w = 7'h5A;
        bus.wr_data  = w;
        bus.wr_valid = 1'b1;
        @(negedge sys_clk);
        bus.wr_valid = 1'b0;
        check("t1 level cyc1", bus.fifo_level, 1);
        check("t1 busy cyc1", bus.busy, 0);
        @(negedge sys_clk);
        check("t1 level cyc2", bus.fifo_level, 0);
        check("t1 busy cyc2", bus.busy, 1);
        wait_cycles(40);
        check("t1 strobe count", strobes.size(), 7);
        for (int i = 0; i < 7; i++) begin
            if (i < strobes.size()) begin
                check($sformatf("t1 strobe%0d cycle", i), strobes[i].at - t0, 5 + 4 * i);
                check($sformatf("t1 strobe%0d bit", i), strobes[i].bit_v, w[6-i]);
            end
        end
        check("t1 busy first", busy_first - t0, 2);
        check("t1 busy last", busy_last - t0, 37);
        check("t1 rx reg", rx, 7'h5A);
        check("t1 word count", words.size(), 1);

        // Back-to-back words 7'h7F then 7'h01.
        clear_logs();
        t0 = cyc;
        bus.wr_data  = 7'h7F;
        bus.wr_valid = 1'b1;
        @(negedge sys_clk);
        bus.wr_data  = 7'h01;
        @(negedge sys_clk);
        bus.wr_valid = 1'b0;
        check("t2 level push+pop", bus.fifo_level, 1);
        wait_cycles(78);
        check("t2 strobe count", strobes.size(), 14);
        if (strobes.size() > 7) check("t2 word2 first strobe", strobes[7].at - t0, 42);
        check("t2 word count", words.size(), 2);
        if (words.size() >= 2) begin
            check("t2 word0", words[0], 7'h7F);
            check("t2 word1", words[1], 7'h01);
        end
        check("t2 busy last", busy_last - t0, 74);

        // FIFO full: 6 offers while busy, only 4 admitted.
        clear_logs();
        t0 = cyc;
        bus.wr_data  = 7'h11;
        bus.wr_valid = 1'b1;
        @(negedge sys_clk);
        bus.wr_valid = 1'b0;
        @(negedge sys_clk);
        check("t3 busy before fill", bus.busy, 1);
        for (int i = 0; i < 6; i++) begin
            bus.wr_data  = 7'h21 + 7'(i);
            bus.wr_valid = 1'b1;
            check($sformatf("t3 wr_ready offer%0d", i), bus.wr_ready, (i < 4) ? 1 : 0);
            @(negedge sys_clk);
        end
        bus.wr_valid = 1'b0;
        check("t3 level full", bus.fifo_level, 4);
        wait_cycles(200);
        check("t3 level peak", level_peak, 4);
        check("t3 level drained", bus.fifo_level, 0);
        check("t3 word count", words.size(), 5);
        if (words.size() == 5) begin
            check("t3 word0", words[0], 7'h11);
            check("t3 word1", words[1], 7'h21);
            check("t3 word2", words[2], 7'h22);
            check("t3 word3", words[3], 7'h23);
            check("t3 word4", words[4], 7'h24);
        end

        // Reset after the third strobe of 7'h55, with 7'h33 still queued.
        clear_logs();
        bus.wr_data  = 7'h55;
        bus.wr_valid = 1'b1;
        @(negedge sys_clk);
        bus.wr_data  = 7'h33;
        @(negedge sys_clk);
        bus.wr_valid = 1'b0;
        for (int k = 0; k < 100 && strobes.size() < 3; k++) @(negedge sys_clk);
        check("t4 third strobe seen", strobes.size() >= 3, 1);
        check("t4 level before reset", bus.fifo_level, 1);
        #1 reset = 1'b1;
        #1;
        check("t4 lock in reset", bus.lock, 1);
        check("t4 data_out in reset", bus.data_out, 0);
        check("t4 level in reset", bus.fifo_level, 0);
        check("t4 busy in reset", bus.busy, 0);
        check("t4 wr_ready in reset", bus.wr_ready, 1);
        wait_cycles(2);
        reset = 1'b0;
        clear_logs();
        wait_cycles(60);
        check("t4 no strobe after reset", strobes.size(), 0);
        check("t4 idle after reset", busy_first, -1);

        // Zero gap: two queued words on the GAP_SLOTS=0 instance.
        clear_logs();
        t0 = cyc;
        bus0.wr_data  = 7'h3C;
        bus0.wr_valid = 1'b1;
        @(negedge sys_clk);
        bus0.wr_data  = 7'h4B;
        @(negedge sys_clk);
        bus0.wr_valid = 1'b0;
        wait_cycles(70);
        check("t5 strobe count", strobes0.size(), 14);
        check("t5 busy rises", busy_rise0.size(), 2);
        if (strobes0.size() >= 14 && busy_rise0.size() >= 2) begin
            check("t5 first strobe", strobes0[0].at - t0, 5);
            check("t5 gap to 2nd shift", busy_rise0[1] - strobes0[6].at, 2);
            check("t5 word2 first strobe", strobes0[7].at - t0, 34);
        end
        check("t5 word count", words0.size(), 2);
        if (words0.size() >= 2) begin
            check("t5 word0", words0[0], 7'h3C);
            check("t5 word1", words0[1], 7'h4B);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
